// File: rtl/usr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : usr_pkg
//  Brief    : Mode codes and serialiser state encoding for universal_shift_reg.
//  Revision : 1.0 - initial release
// ============================================================================
package usr_pkg;

    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_RSVD  = 3'b110;
    localparam logic [2:0] MODE_CLEAR = 3'b111;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage : usr_pkg
`default_nettype wire

// File: rtl/usr_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : usr_serial_ctrl
//  Brief    : Serialiser sequencer: IDLE/SHIFT FSM with bit counter, emitting
//             load/shift enables and registered busy/done flags.
//  Revision : 1.0 - initial release
// ============================================================================
module usr_serial_ctrl
    import usr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    output logic o_shift_en,
    output logic o_load_en,
    output logic o_busy,
    output logic o_done
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(N - 1);

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_done;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (r_state == ST_IDLE) begin
            if (i_start) begin
                w_state_nxt = ST_SHIFT;
                w_cnt_nxt   = '0;
            end
        end else begin
            if (r_cnt == c_cnt_last) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
            end
        end
    end

    // done is decoded one cycle early so it arrives as a flop output
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= (w_state_nxt == ST_SHIFT) && (w_cnt_nxt == c_cnt_last);
        end
    end

    assign o_busy     = (r_state == ST_SHIFT);
    assign o_done     = r_done;
    assign o_shift_en = (r_state == ST_SHIFT);
    assign o_load_en  = (r_state == ST_IDLE) && i_start;

endmodule : usr_serial_ctrl
`default_nettype wire

// File: rtl/universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : universal_shift_reg
//  Brief    : N-bit universal register (load/shift/rotate/clear) with an
//             autonomous MSB-first full-duplex serialiser.
//             Optional even-parity output enabled by `define USR_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module universal_shift_reg
    import usr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [2:0]   i_mode,
    input  logic         i_start,
    input  logic [N-1:0] i_parallel_in,
    input  logic         i_serial_in,
    output logic [N-1:0] o_parallel_out,
    output logic         o_serial_msb,
    output logic         o_serial_lsb,
    output logic         o_busy,
    output logic         o_done
`ifdef USR_PARITY_EN
    ,
    output logic         o_parity
`endif
);

    logic [N-1:0] r_reg;
    logic [N-1:0] w_reg_nxt;
    logic         w_shift_en;
    logic         w_load_en;

    usr_serial_ctrl #(
        .N (N)
    ) u_ctrl (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .o_shift_en (w_shift_en),
        .o_load_en  (w_load_en),
        .o_busy     (o_busy),
        .o_done     (o_done)
    );

    // Serialiser owns the register while active; manual modes only act when idle
    always_comb begin
        w_reg_nxt = r_reg;
        if (w_shift_en) begin
            w_reg_nxt = {r_reg[N-2:0], i_serial_in};
        end else if (w_load_en) begin
            w_reg_nxt = i_parallel_in;
        end else begin
            case (i_mode)
                MODE_LOAD:  w_reg_nxt = i_parallel_in;
                MODE_SHL:   w_reg_nxt = {r_reg[N-2:0], i_serial_in};
                MODE_SHR:   w_reg_nxt = {i_serial_in, r_reg[N-1:1]};
                MODE_ROTL:  w_reg_nxt = {r_reg[N-2:0], r_reg[N-1]};
                MODE_ROTR:  w_reg_nxt = {r_reg[0], r_reg[N-1:1]};
                MODE_CLEAR: w_reg_nxt = '0;
                default:    w_reg_nxt = r_reg;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_reg <= '0;
        end else begin
            r_reg <= w_reg_nxt;
        end
    end

    assign o_parallel_out = r_reg;
    assign o_serial_msb   = r_reg[N-1];
    assign o_serial_lsb   = r_reg[0];

`ifdef USR_PARITY_EN
    assign o_parity = ^r_reg;
`endif

endmodule : universal_shift_reg
`default_nettype wire

// File: tb/tb_universal_shift_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_universal_shift_reg
//  Brief    : Scoreboard bench for universal_shift_reg (N=4): directed cases
//             followed by randomized traffic against a cycle-count model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_universal_shift_reg;

    localparam int N    = 4;
    localparam int MASK = (1 << N) - 1;

    typedef struct {
        int par;
        int msb;
        int lsb;
        int busy;
        int done;
    } exp_t;

    logic         clk;
    logic         i_rst;
    logic [2:0]   i_mode;
    logic         i_start;
    logic [N-1:0] i_parallel_in;
    logic         i_serial_in;
    logic [N-1:0] o_parallel_out;
    logic         o_serial_msb;
    logic         o_serial_lsb;
    logic         o_busy;
    logic         o_done;
`ifdef USR_PARITY_EN
    logic         o_parity;
`endif

    universal_shift_reg #(.N(N)) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_mode         (i_mode),
        .i_start        (i_start),
        .i_parallel_in  (i_parallel_in),
        .i_serial_in    (i_serial_in),
        .o_parallel_out (o_parallel_out),
        .o_serial_msb   (o_serial_msb),
        .o_serial_lsb   (o_serial_lsb),
        .o_busy         (o_busy),
        .o_done         (o_done)
`ifdef USR_PARITY_EN
        ,
        .o_parity       (o_parity)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Model: register value plus position inside a serialisation (0 = idle)
    int   m_reg  = 0;
    int   m_word = 0;
    int   m_cyc  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t cur_exp();
        exp_t e;
        e.par  = m_reg;
        e.busy = (m_cyc != 0) ? 1 : 0;
        e.done = (m_cyc == N) ? 1 : 0;
        e.msb  = (m_cyc != 0) ? ((m_word >> (N - m_cyc)) & 1) : ((m_reg >> (N - 1)) & 1);
        e.lsb  = m_reg & 1;
        return e;
    endfunction

    task automatic step(input logic st, input logic [2:0] md, input logic [N-1:0] pin, input logic si);
        @(negedge clk);
        i_rst = 1'b0; i_start = st; i_mode = md; i_parallel_in = pin; i_serial_in = si;
        if (m_cyc == 0) begin
            if (st) begin
                m_word = int'(pin);
                m_reg  = int'(pin);
                m_cyc  = 1;
            end else begin
                case (md)
                    3'd1: m_reg = int'(pin);
                    3'd2: m_reg = ((m_reg << 1) | int'(si)) & MASK;
                    3'd3: m_reg = (m_reg >> 1) | (int'(si) << (N - 1));
                    3'd4: m_reg = ((m_reg << 1) | (m_reg >> (N - 1))) & MASK;
                    3'd5: m_reg = (m_reg >> 1) | ((m_reg & 1) << (N - 1));
                    3'd7: m_reg = 0;
                    default: m_reg = m_reg;
                endcase
            end
        end else begin
            m_reg = ((m_reg << 1) | int'(si)) & MASK;
            m_cyc = (m_cyc == N) ? 0 : m_cyc + 1;
        end
        q_exp.push_back(cur_exp());
    endtask

    // Reset mid-cycle, check outputs before any edge, hold through one edge
    task automatic reset_mid();
        @(negedge clk);
        i_start = 1'b0; i_mode = 3'b000;
        #2 i_rst = 1'b1;
        #1;
        chk("rst_async_par",  32'(o_parallel_out), 32'd0);
        chk("rst_async_busy", 32'(o_busy), 32'd0);
        chk("rst_async_done", 32'(o_done), 32'd0);
        m_reg = 0;
        m_cyc = 0;
        q_exp.push_back(cur_exp());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e = q_exp.pop_front();
                chk("par",  32'(o_parallel_out), 32'(e.par));
                chk("msb",  32'(o_serial_msb),   32'(e.msb));
                chk("lsb",  32'(o_serial_lsb),   32'(e.lsb));
                chk("busy", 32'(o_busy),         32'(e.busy));
                chk("done", 32'(o_done),         32'(e.done));
`ifdef USR_PARITY_EN
                chk("parity", 32'(o_parity), 32'(^e.par[N-1:0]));
`endif
            end
        end
    end

    initial begin : driver
        i_rst = 1'b1; i_start = 1'b0; i_mode = 3'b000;
        i_parallel_in = '0; i_serial_in = 1'b0;
        #1;
        chk("rst_init_par",  32'(o_parallel_out), 32'd0);
        chk("rst_init_busy", 32'(o_busy), 32'd0);

        // async reset with register full of ones
        step(1'b0, 3'b001, 4'b1111, 1'b0);
        step(1'b0, 3'b000, 4'b0000, 1'b0);
        reset_mid();

        // manual modes
        step(1'b0, 3'b001, 4'b1010, 1'b0);
        step(1'b0, 3'b100, 4'b0000, 1'b0);
        step(1'b0, 3'b101, 4'b0000, 1'b0);
        step(1'b0, 3'b011, 4'b0000, 1'b1);
        step(1'b0, 3'b010, 4'b0000, 1'b0);
        step(1'b0, 3'b111, 4'b0000, 1'b0);
        step(1'b0, 3'b001, 4'b0110, 1'b0);
        step(1'b0, 3'b000, 4'b1111, 1'b1);
        step(1'b0, 3'b110, 4'b1111, 1'b1);

        // serialise 1011 with input stream 0,1,1,0
        step(1'b1, 3'b000, 4'b1011, 1'b0);
        step(1'b0, 3'b000, 4'b0000, 1'b0);
        step(1'b0, 3'b000, 4'b0000, 1'b1);
        step(1'b0, 3'b000, 4'b0000, 1'b1);
        step(1'b0, 3'b000, 4'b0000, 1'b0);
        step(1'b0, 3'b000, 4'b0000, 1'b0);

        // start/clear held while busy, then back-to-back start
        step(1'b1, 3'b111, 4'b1100, 1'b1);
        for (int i = 0; i < N; i++) step(1'b1, 3'b111, 4'b0011, 1'(i & 1));
        step(1'b1, 3'b000, 4'b1001, 1'b1);
        for (int i = 0; i < N; i++) step(1'b0, 3'b000, 4'b0000, 1'b0);

        // reset in the second busy cycle, then a fresh run
        step(1'b1, 3'b000, 4'b1111, 1'b1);
        step(1'b0, 3'b000, 4'b0000, 1'b1);
        reset_mid();
        step(1'b1, 3'b000, 4'b0101, 1'b0);
        for (int i = 0; i < N + 1; i++) step(1'b0, 3'b000, 4'b0000, 1'b1);

        // parity-oriented loads
        step(1'b0, 3'b001, 4'b0111, 1'b0);
        step(1'b0, 3'b001, 4'b0101, 1'b0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 3) begin
                reset_mid();
            end else begin
                step(1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                     N'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        step(1'b0, 3'b000, 4'b0000, 1'b0);
        for (int i = 0; i < 5 && q_exp.size() > 0; i++) @(negedge clk);
        if (q_exp.size() > 0) begin
            n_err++;
            $display("FAIL drain: got %0d pending expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_universal_shift_reg
`default_nettype wire
